// File: rtl/uart_cmd_framer.sv
// ============================================================================
// uart_cmd_framer : UART byte stream <-> command word framer with command FIFO,
//                   inter-byte timeout and MSB-first response serialiser.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_framer #(
    parameter int CMD_BYTES   = 2,
    parameter int RESP_BYTES  = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_rdy,
    input  logic [7:0]              rx_data,
    output logic                    clr_rx_rdy,
    output logic                    trmt,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    cmd_rdy,
    input  logic                    clr_cmd_rdy,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    send_resp,
    output logic                    resp_busy,
    output logic                    overflow,
    output logic                    timeout
);

    localparam int CW = 8 * CMD_BYTES;
    localparam int RW = 8 * RESP_BYTES;
    localparam int IW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int BW = $clog2(RESP_BYTES + 1);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    // ---------------- RX assembly and gap timer ----------------
    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_shift;
    logic [TW-1:0] r_gap;
    logic          w_last;
    logic          w_expire;
    logic [CW-1:0] w_word;

    assign clr_rx_rdy = rx_rdy;
    assign w_last     = rx_rdy && (r_idx == IW'(CMD_BYTES - 1));
    assign w_word     = (r_shift << 8) | CW'(rx_data);
    assign w_expire   = TO_EN && !rx_rdy && (r_idx != '0) && (r_gap == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_shift <= '0;
            r_gap   <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if (rx_rdy) begin
                r_shift <= w_last ? '0 : w_word;
                r_idx   <= w_last ? '0 : r_idx + 1'b1;
                r_gap   <= '0;
            end else if (w_expire) begin
                r_idx   <= '0;
                r_shift <= '0;
                r_gap   <= '0;
                timeout <= 1'b1;
            end else if (TO_EN && (r_idx != '0)) begin
                r_gap   <= r_gap + 1'b1;
            end
        end
    end

    // ---------------- command FIFO ----------------
    logic [CW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_pop;
    logic          w_full;
    logic          w_push;

    assign w_pop   = clr_cmd_rdy && (r_cnt != '0);
    assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_push  = w_last && (!w_full || w_pop);
    assign cmd     = r_mem[r_rd];
    assign cmd_rdy = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= w_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= w_last && w_full && !w_pop;
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // ---------------- TX response serialiser ----------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } tx_state_t;

    tx_state_t     r_state;
    logic [RW-1:0] r_resp;
    logic [BW-1:0] r_left;
    logic          r_done_d;
    logic          w_rise;

    assign w_rise = tx_done && !r_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_resp    <= '0;
            r_left    <= '0;
            r_done_d  <= 1'b0;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            resp_busy <= 1'b0;
        end else begin
            r_done_d <= tx_done;
            trmt     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (send_resp) begin
                        tx_data   <= resp[RW-1 -: 8];
                        r_resp    <= resp << 8;
                        r_left    <= BW'(RESP_BYTES - 1);
                        trmt      <= 1'b1;
                        resp_busy <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (w_rise) begin
                        if (r_left == '0) begin
                            resp_busy <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            tx_data <= r_resp[RW-1 -: 8];
                            r_resp  <= r_resp << 8;
                            r_left  <= r_left - 1'b1;
                            trmt    <= 1'b1;
                            r_state <= S_LOAD;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
